xnor3_bist_sequencer: RTL and testbench

Built-in self-test sequencer for the three-input XNOR gate. On a start pulse it walks all 8 input combinations into the gate and waits a programmable settle time per vector. It compares the gate output against the expected XNOR value and reports pass/fail, an error count and the first failing vector. It sits beside the gate and drives the gate's first/second/third inputs directly.

---
 rtl/xnor3_bist_sequencer_if.sv | 51 +++++
 rtl/xnor3_bist_sequencer.sv | 159 +++++++++++++++
 tb/tb_xnor3_bist_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xnor3_bist_sequencer_if.sv
// ============================================================================
// Module      : xnor3_bist_sequencer_if
// Description : Control/result and gate-under-test signals of the XNOR3 BIST
//               sequencer, with master (sequencer) and slave (environment) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xnor3_bist_sequencer_if;
    logic       start;
    logic       gate_out;
    logic       first;
    logic       second;
    logic       third;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] fail_vec;
    logic       fail_valid;

    modport master (
        input  start,
        input  gate_out,
        output first,
        output second,
        output third,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output fail_valid
    );

    modport slave (
        output start,
        output gate_out,
        input  first,
        input  second,
        input  third,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  fail_valid
    );
endinterface

`default_nettype wire

// File: rtl/xnor3_bist_sequencer.sv
// ============================================================================
// Module      : xnor3_bist_sequencer
// Description : Walks all 8 vectors into a 3-input XNOR gate, checks each
//               result and reports pass/fail, error count and first failure.
//               Optional macro XNOR3_BIST_STOP_ON_FAIL_EN ends the run at the
//               first mismatching vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xnor3_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    xnor3_bist_sequencer_if.master bus
);

    localparam logic [3:0] c_WAIT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] c_VEC_LAST  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_vec;
    logic [3:0] r_wcnt;
    logic [3:0] r_err;
    logic [2:0] r_fvec;
    logic       r_fvalid;
    logic       r_pass;
    logic       r_done;
    logic       r_busy;
    logic [2:0] r_gate;

    state_t     w_state_n;
    logic [2:0] w_vec_n;
    logic [3:0] w_wcnt_n;
    logic [3:0] w_err_n;
    logic [2:0] w_fvec_n;
    logic       w_fvalid_n;
    logic       w_pass_n;
    logic       w_drive_n;
    logic [2:0] w_gate_n;
    logic       w_exp;
    logic       w_mismatch;

    assign w_exp      = ~(r_vec[2] ^ r_vec[1] ^ r_vec[0]);
    assign w_mismatch = (bus.gate_out != w_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_vec    <= 3'd0;
            r_wcnt   <= 4'd0;
            r_err    <= 4'd0;
            r_fvec   <= 3'd0;
            r_fvalid <= 1'b0;
            r_pass   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_gate   <= 3'd0;
        end else begin
            r_state  <= w_state_n;
            r_vec    <= w_vec_n;
            r_wcnt   <= w_wcnt_n;
            r_err    <= w_err_n;
            r_fvec   <= w_fvec_n;
            r_fvalid <= w_fvalid_n;
            r_pass   <= w_pass_n;
            r_done   <= (w_state_n == S_DONE);
            r_busy   <= w_drive_n;
            r_gate   <= w_gate_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_vec_n    = r_vec;
        w_wcnt_n   = r_wcnt;
        w_err_n    = r_err;
        w_fvec_n   = r_fvec;
        w_fvalid_n = r_fvalid;
        w_pass_n   = r_pass;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_n  = S_DRIVE;
                    w_vec_n    = 3'd0;
                    w_wcnt_n   = 4'd0;
                    w_err_n    = 4'd0;
                    w_fvec_n   = 3'd0;
                    w_fvalid_n = 1'b0;
                    w_pass_n   = 1'b0;
                end
            end

            S_DRIVE: begin
                w_wcnt_n = r_wcnt + 4'd1;
                if (r_wcnt == c_WAIT_LAST) begin
                    w_state_n = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_n = r_err + 4'd1;
                    if (!r_fvalid) begin
                        w_fvec_n   = r_vec;
                        w_fvalid_n = 1'b1;
                    end
                end
`ifdef XNOR3_BIST_STOP_ON_FAIL_EN
                if (w_mismatch || (r_vec == c_VEC_LAST)) begin
`else
                if (r_vec == c_VEC_LAST) begin
`endif
                    w_state_n = S_DONE;
                    // pass must reflect a mismatch found in this very CHECK
                    w_pass_n  = (w_err_n == 4'd0);
                end else begin
                    w_state_n = S_DRIVE;
                    w_vec_n   = r_vec + 3'd1;
                    w_wcnt_n  = 4'd0;
                end
            end

            S_DONE: begin
                w_state_n = S_IDLE;
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        w_drive_n = (w_state_n == S_DRIVE) || (w_state_n == S_CHECK);
        w_gate_n  = w_drive_n ? w_vec_n : 3'd0;
    end

    assign bus.first      = r_gate[2];
    assign bus.second     = r_gate[1];
    assign bus.third      = r_gate[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.fail_vec   = r_fvec;
    assign bus.fail_valid = r_fvalid;

endmodule

`default_nettype wire

// File: tb/tb_xnor3_bist_sequencer.sv
// ============================================================================
// Module      : tb_xnor3_bist_sequencer
// Description : Directed bench for xnor3_bist_sequencer with a gate model and a
//               result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xnor3_bist_sequencer;

    localparam int S       = 2;
    localparam int VEC_CYC = S + 1;
    localparam int LAT_ALL = 8 * VEC_CYC + 1;

    logic clk = 1'b0;
    logic reset;
    int   mode;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xnor3_bist_sequencer_if bus();

    xnor3_bist_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] err;
        logic [2:0] fvec;
        logic       fvalid;
        logic       pass;
        int         latency;
    } exp_t;

    exp_t sb[$];

    // mode 0: good XNOR, 1: stuck-at-0, 2: stuck-at-1, 3: XOR
    function automatic logic gate_model(input int m, input logic [2:0] v);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[2] ^ v[1] ^ v[0];
            default: return ~(v[2] ^ v[1] ^ v[0]);
        endcase
    endfunction

    function automatic exp_t predict(input int m);
        exp_t       e;
        logic [2:0] vv;
        e.err = 4'd0; e.fvec = 3'd0; e.fvalid = 1'b0; e.latency = LAT_ALL;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            if (gate_model(m, vv) !== ~(vv[2] ^ vv[1] ^ vv[0])) begin
                e.err = e.err + 4'd1;
                if (!e.fvalid) begin
                    e.fvec   = vv;
                    e.fvalid = 1'b1;
                end
`ifdef XNOR3_BIST_STOP_ON_FAIL_EN
                e.latency = (v + 1) * VEC_CYC + 1;
                break;
`endif
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    always_comb bus.gate_out = gate_model(mode, {bus.first, bus.second, bus.third});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full run; n counts cycles after the start-sampling cycle (cycle 0)
    task automatic do_run(input int m, input int extra_start, input bit chk_vec);
        exp_t e;
        int   n;
        bit   seen;
        mode = m;
        e    = predict(m);
        sb.push_back(e);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n    = 1;
        seen = 1'b0;
        check("busy_c1", 32'(bus.busy), 32'd1);
        while (!seen && n < 200) begin
            bus.start = (n == extra_start);
            if (chk_vec && n < LAT_ALL)
                check("vec_seq", 32'({bus.first, bus.second, bus.third}), 32'((n - 1) / VEC_CYC));
            if (bus.done) begin
                seen = 1'b1;
                e    = sb.pop_front();
                check("done_cycle", 32'(n),              32'(e.latency));
                check("pass",       32'(bus.pass),       32'(e.pass));
                check("err_count",  32'(bus.err_count),  32'(e.err));
                check("fail_vec",   32'(bus.fail_vec),   32'(e.fvec));
                check("fail_valid", 32'(bus.fail_valid), 32'(e.fvalid));
                check("busy_done",  32'(bus.busy),       32'd0);
                check("gate_done",  32'({bus.first, bus.second, bus.third}), 32'd0);
            end else begin
                step();
                n++;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        bus.start = 1'b0;
        step();
        check("done_pulse", 32'(bus.done),      32'd0);
        check("pass_hold",  32'(bus.pass),      32'(e.pass));
        check("err_hold",   32'(bus.err_count), 32'(e.err));
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        mode      = 0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_outputs", 32'({bus.first, bus.second, bus.third, bus.busy, bus.done,
                                  bus.pass, bus.err_count, bus.fail_vec, bus.fail_valid}), 32'd0);

        do_run(0, -1, 1'b1);   // good gate, full vector walk
        do_run(1, -1, 1'b0);   // stuck-at-0
        do_run(2, -1, 1'b0);   // stuck-at-1
        do_run(3, 10, 1'b0);   // XOR gate, ignored restart at cycle 10

        // reset during vector 3, then a clean run
        mode      = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("vec3_before_rst", 32'({bus.first, bus.second, bus.third}), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrun_rst", 32'({bus.first, bus.second, bus.third, bus.busy, bus.done,
                                 bus.pass, bus.err_count, bus.fail_vec, bus.fail_valid}), 32'd0);
        step();
        check("idle_after_rst", 32'(bus.busy), 32'd0);
        do_run(0, -1, 1'b1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
